// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and the bit-reversal helper used by the FFT
// result unloader.
package fft_pkg;

  localparam int FFT_N_POINTS = 16;
  localparam int FFT_ADDR_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } unload_state_t;

  // Reverses the low 'width' bits of value; bits above 'width' come back as 0.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < width; b++) begin
      r[b] = value[width-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_unloader.sv
// Reads all N FFT bins after the control unit reports completion, streams them
// out over valid/ready and pulses o_restart. Macro FFT_UNLOAD_BITREV_EN selects
// bit-reversed read addressing.
module fft_result_unloader
  import fft_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_POINTS = fft_pkg::FFT_N_POINTS,
  parameter int ADDR_W   = fft_pkg::FFT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cycle_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_re,
  input  logic [DATA_W-1:0] i_rd_im,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_re,
  output logic [DATA_W-1:0] o_im,
  output logic [ADDR_W-1:0] o_index,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_restart,
  output logic              o_overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  // Valid/ready: a bin transfers on any clock edge where o_valid && i_ready;
  // once o_valid rises, o_re/o_im/o_index/o_last hold until that transfer.

  unload_state_t     r_state;
  logic              r_cycle_done_q;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_valid;
  logic [DATA_W-1:0] r_re;
  logic [DATA_W-1:0] r_im;
  logic [ADDR_W-1:0] r_out_index;
  logic              r_last;
  logic              r_busy;
  logic              r_restart;
  logic              r_overrun;

  logic              w_start;
  logic              w_accept;
  logic [ADDR_W-1:0] w_next_index;

  function automatic logic [ADDR_W-1:0] rd_addr_of(input logic [ADDR_W-1:0] idx);
`ifdef FFT_UNLOAD_BITREV_EN
    logic [31:0] rev;
    rev = bit_reverse(32'(idx), ADDR_W);
    return rev[ADDR_W-1:0];
`else
    return idx;
`endif
  endfunction

  assign w_start      = i_cycle_done && !r_cycle_done_q;
  assign w_accept     = r_valid && i_ready;
  assign w_next_index = r_index + 1'b1;

  // Read address is registered on entry to FETCH so the buffer data is
  // present for the whole FETCH cycle and captured at its closing edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cycle_done_q <= 1'b0;
      r_index        <= '0;
      r_rd_addr      <= '0;
      r_valid        <= 1'b0;
      r_re           <= '0;
      r_im           <= '0;
      r_out_index    <= '0;
      r_last         <= 1'b0;
      r_busy         <= 1'b0;
      r_restart      <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_cycle_done_q <= i_cycle_done;
      if (w_start && r_state != ST_IDLE) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_rd_addr <= '0;
          if (w_start) begin
            r_index   <= '0;
            r_rd_addr <= rd_addr_of('0);
            r_busy    <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_re        <= i_rd_re;
          r_im        <= i_rd_im;
          r_out_index <= r_index;
          r_valid     <= 1'b1;
          r_last      <= (r_index == LAST_IDX);
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_last    <= 1'b0;
              r_restart <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_index   <= w_next_index;
              r_rd_addr <= rd_addr_of(w_next_index);
              r_state   <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_restart <= 1'b0;
          r_busy    <= 1'b0;
          r_rd_addr <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_addr = r_rd_addr;
  assign o_valid   = r_valid;
  assign o_re      = r_re;
  assign o_im      = r_im;
  assign o_index   = r_out_index;
  assign o_last    = r_last;
  assign o_busy    = r_busy;
  assign o_restart = r_restart;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Directed bench for fft_result_unloader: table of frame scenarios plus
// hand-written reset-abort and hold-high sequences.
module tb_fft_result_unloader;
  import fft_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NPTS   = 16;

  logic              i_clk;
  logic              i_rst;
  logic              i_cycle_done;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_re;
  logic [DATA_W-1:0] i_rd_im;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_re;
  logic [DATA_W-1:0] o_im;
  logic [ADDR_W-1:0] o_index;
  logic              o_last;
  logic              o_busy;
  logic              o_restart;
  logic              o_overrun;

  logic [DATA_W-1:0] mem_re [NPTS];
  logic [DATA_W-1:0] mem_im [NPTS];

  int n_checks;
  int n_errors;
  int restart_cnt;

  typedef struct {
    int   stall_bin;
    int   stall_cycles;
    int   ovr_bin;
    logic exp_overrun;
  } frame_vec_t;

  frame_vec_t vecs [5];

  fft_result_unloader #(.DATA_W(DATA_W), .N_POINTS(NPTS), .ADDR_W(ADDR_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cycle_done (i_cycle_done),
    .o_rd_addr    (o_rd_addr),
    .i_rd_re      (i_rd_re),
    .i_rd_im      (i_rd_im),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_re         (o_re),
    .o_im         (o_im),
    .o_index      (o_index),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_restart    (o_restart),
    .o_overrun    (o_overrun)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Result buffer: data follows the registered read address within the cycle
  assign i_rd_re = mem_re[o_rd_addr];
  assign i_rd_im = mem_im[o_rd_addr];

  always @(posedge i_clk) begin
    if (o_restart) restart_cnt++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input int k);
    logic [ADDR_W-1:0] kk;
    logic [ADDR_W-1:0] r;
    kk = ADDR_W'(k);
`ifdef FFT_UNLOAD_BITREV_EN
    for (int b = 0; b < ADDR_W; b++) r[b] = kk[ADDR_W-1-b];
`else
    r = kk;
`endif
    return r;
  endfunction

  task automatic run_frame(input frame_vec_t v);
    int                rs0;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e_re;
    logic [DATA_W-1:0] e_im;
    rs0 = restart_cnt;
    i_ready = 1'b1;
    i_cycle_done = 1'b0;
    tick();
    i_cycle_done = 1'b1;
    tick();
    check("start_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < NPTS; k++) begin
      a = exp_addr(k);
      e_re = DATA_W'(a);
      e_im = DATA_W'(0) - e_re;
      check("fetch_rd_addr", 32'(o_rd_addr), 32'(a));
      check("fetch_valid", 32'(o_valid), 32'd0);
      tick();
      check("send_valid", 32'(o_valid), 32'd1);
      check("send_re", 32'(o_re), 32'(e_re));
      check("send_im", 32'(o_im), 32'(e_im));
      check("send_index", 32'(o_index), 32'(k));
      check("send_last", 32'(o_last), 32'(k == NPTS - 1));
      if (k == v.stall_bin) begin
        i_ready = 1'b0;
        for (int s = 0; s < v.stall_cycles; s++) begin
          tick();
          check("stall_valid", 32'(o_valid), 32'd1);
          check("stall_re", 32'(o_re), 32'(e_re));
          check("stall_index", 32'(o_index), 32'(k));
          check("stall_last", 32'(o_last), 32'(k == NPTS - 1));
        end
      end
      if (k == v.ovr_bin) begin
        i_ready = 1'b0;
        i_cycle_done = 1'b0;
        tick();
        i_cycle_done = 1'b1;
        tick();
        check("ovr_flag", 32'(o_overrun), 32'd1);
        check("ovr_valid_held", 32'(o_valid), 32'd1);
        check("ovr_index_held", 32'(o_index), 32'(k));
      end
      i_ready = 1'b1;
      tick();
      if (k < NPTS - 1) begin
        check("accept_valid_drop", 32'(o_valid), 32'd0);
        check("accept_no_restart", 32'(o_restart), 32'd0);
      end else begin
        check("done_restart", 32'(o_restart), 32'd1);
        check("done_valid", 32'(o_valid), 32'd0);
        check("done_last_clr", 32'(o_last), 32'd0);
      end
    end
    tick();
    check("idle_restart", 32'(o_restart), 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_rd_addr", 32'(o_rd_addr), 32'd0);
    check("idle_overrun", 32'(o_overrun), 32'(v.exp_overrun));
    check("restart_once", 32'(restart_cnt - rs0), 32'd1);
    // i_cycle_done is still high: no new frame may start
    for (int h = 0; h < 3; h++) begin
      tick();
      check("hold_busy", 32'(o_busy), 32'd0);
      check("hold_valid", 32'(o_valid), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_re"}, 32'(o_re), 32'd0);
    check({tag, "_im"}, 32'(o_im), 32'd0);
    check({tag, "_index"}, 32'(o_index), 32'd0);
    check({tag, "_last"}, 32'(o_last), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_restart"}, 32'(o_restart), 32'd0);
    check({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    check({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
    check({tag, "_state"}, 32'(dut.r_state), 32'(ST_IDLE));
  endtask

  initial begin
    int rs0;
    n_checks = 0;
    n_errors = 0;
    restart_cnt = 0;
    for (int k = 0; k < NPTS; k++) begin
      mem_re[k] = DATA_W'(k);
      mem_im[k] = DATA_W'(0) - DATA_W'(k);
    end
    vecs[0] = '{stall_bin: -1, stall_cycles: 0, ovr_bin: -1, exp_overrun: 1'b0};
    vecs[1] = '{stall_bin:  3, stall_cycles: 5, ovr_bin: -1, exp_overrun: 1'b0};
    vecs[2] = '{stall_bin: -1, stall_cycles: 0, ovr_bin:  7, exp_overrun: 1'b1};
    vecs[3] = '{stall_bin: -1, stall_cycles: 0, ovr_bin: -1, exp_overrun: 1'b1};
    vecs[4] = '{stall_bin: 15, stall_cycles: 3, ovr_bin: -1, exp_overrun: 1'b1};

    i_rst = 1'b1;
    i_cycle_done = 1'b0;
    i_ready = 1'b0;
    #12;
    check_all_zero("reset");
    i_rst = 1'b0;
    tick();
    check("post_reset_busy", 32'(o_busy), 32'd0);

    for (int f = 0; f < 5; f++) begin
      run_frame(vecs[f]);
    end

    // Abort with asynchronous reset while bin 10 is being offered
    i_ready = 1'b1;
    i_cycle_done = 1'b0;
    tick();
    i_cycle_done = 1'b1;
    tick();
    for (int c = 0; c < 20; c++) tick();
    tick();
    i_ready = 1'b0;
    check("abort_pre_index", 32'(o_index), 32'd10);
    check("abort_pre_valid", 32'(o_valid), 32'd1);
    rs0 = restart_cnt;
    #2;
    i_rst = 1'b1;
    i_cycle_done = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    check("abort_hold_restart", 32'(o_restart), 32'd0);
    #2;
    i_rst = 1'b0;
    tick();
    check("abort_no_restart_pulse", 32'(restart_cnt - rs0), 32'd0);
    check("abort_idle_valid", 32'(o_valid), 32'd0);

    // Fresh frame after the abort starts at index 0 with overrun cleared
    run_frame(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_result_unloader.md
Name: fft_result_unloader

Overview:
- Consumer side of the FFT sequencing handshake.
- Waits for the FFT control unit to report cycle completion, then reads all N result bins from the result buffer read port.
- Streams the bins out over a valid/ready interface, in natural bin order.
- After the final bin is accepted, pulses a restart request that re-arms the control unit for the next frame.

Parameters:
- DATA_W, 16, width of each real/imag component.
- N_POINTS, 16, number of FFT bins per frame (power of two).
- ADDR_W, 4, log2(N_POINTS); width of bin index and read address.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_cycle_done  input  1  level from control unit; high = FFT results stable.
- o_rd_addr  output  ADDR_W  result-buffer read address.
- i_rd_re  input  DATA_W  read data, real part; valid 1 cycle after o_rd_addr.
- i_rd_im  input  DATA_W  read data, imag part; valid 1 cycle after o_rd_addr.
- o_valid  output  1  output bin valid.
- i_ready  input  1  downstream accepts bin when o_valid && i_ready.
- o_re  output  DATA_W  bin real part.
- o_im  output  DATA_W  bin imag part.
- o_index  output  ADDR_W  natural-order bin number of the current output.
- o_last  output  1  high with the bin whose o_index = N_POINTS-1.
- o_busy  output  1  high from frame start until restart pulse.
- o_restart  output  1  one-cycle pulse; drives the control unit reset/re-arm.
- o_overrun  output  1  sticky; a new cycle_done rising edge arrived while busy.

Behaviour:
- Reset (async): state IDLE. All of the following are 0: o_valid, o_re, o_im, o_index, o_last, o_busy, o_restart, o_overrun, o_rd_addr, index counter, and the edge-detect register.
- Edge detect: a registered copy of i_cycle_done. A start is i_cycle_done=1 while the previous value was 0.
- State IDLE:
  - o_rd_addr = 0.
  - On start: index := 0, o_busy := 1, go to FETCH.
- State FETCH (1 cycle):
  - o_rd_addr = addr(index).
  - Next cycle: capture i_rd_re/i_rd_im into o_re/o_im, o_index := index, o_valid := 1, o_last := (index == N_POINTS-1). Go to SEND.
- State SEND:
  - o_re, o_im, o_index and o_last are held stable while o_valid && !i_ready. o_valid must not drop without acceptance.
  - On acceptance with o_last=0: o_valid := 0, index += 1, go to FETCH.
  - On acceptance with o_last=1: o_valid := 0, o_last := 0, go to DONE.
- State DONE (1 cycle):
  - o_restart = 1, o_busy := 0, go to IDLE.
- Throughput is one bin per 2 cycles when i_ready is held high. Start edge to first o_valid is 2 cycles.
- Index wrap: the index counter is ADDR_W bits. It never increments past N_POINTS-1; the DONE transition occurs first.
- Simultaneous events:
  - A start edge while busy (any state other than IDLE) is ignored for sequencing and sets o_overrun=1.
  - A start edge in the same cycle as DONE also counts as overrun.
  - o_overrun clears only on reset.
- i_cycle_done staying high after restart: no new start is generated until it goes low and high again.
- Reset mid-frame aborts immediately. There is no partial restart pulse; the control unit is reset by i_rst directly.
- Output register values are left unchanged in IDLE after a frame; only o_valid gates them.

Optional Feature:
- Macro FFT_UNLOAD_BITREV_EN.
- Defined: addr(index) = bit-reverse of index over ADDR_W bits, for a core that stores results in bit-reversed order. o_index stays natural order. Example: index 1 -> o_rd_addr 8 for N=16.
- Undefined: addr(index) = index.

Decomposition:
- Shared package fft_pkg:
  - N_POINTS and ADDR_W constants.
  - FSM state encoding (IDLE, FETCH, SEND, DONE; 2-bit).
  - bit_reverse function, parameterised by ADDR_W.
- No sub-module required: the FSM, counter and output register fit in one module. The bit reversal is the package function.

Test Plan:
- Reset then i_cycle_done 0->1, i_ready=1, buffer holding re=k, im=-k at address k (macro undefined):
  - 16 bins out, o_index 0..15, o_re=0..15.
  - o_last only on index 15.
  - o_restart pulses once, 1 cycle after the last acceptance.
  - o_busy low afterwards.
- Backpressure: i_ready=0 for 5 cycles while bin 3 is valid:
  - o_valid, o_re=3 and o_index=3 held steady for all 5 cycles.
  - No skip and no duplicate when i_ready rises.
- FFT_UNLOAD_BITREV_EN defined, same buffer contents:
  - o_rd_addr sequence 0,8,4,12,2,...,15.
  - o_re equals the bit-reversed index while o_index is 0..15.
- Second 0->1 edge of i_cycle_done during bin 7:
  - o_overrun=1 (sticky); the current frame completes normally.
  - No second frame starts until a fresh edge arrives after DONE.
- Async i_rst asserted mid-SEND at bin 10:
  - All outputs 0 immediately, state IDLE, o_restart not pulsed.
  - A new edge restarts the frame at index 0.
- i_cycle_done held high through DONE: no second frame starts. Toggling it low then high starts exactly one new frame.
